spine_xbar_scheduler: RTL and testbench

Per-cycle crossbar scheduler for the 11-port spine router in group 6. Each input port's head flit is destined for exactly one output port. For every output, the block picks one requesting input per cycle using an independent round-robin arbiter. It then drives the crossbar select and write strobe for that output and the pop strobe back to the winning input FIFO. It sits between the input-port FIFOs (first-word-fall-through) and the output-port FIFOs of the router ports, and replaces ad-hoc priority selection in the routing FSM.

---
 rtl/spine_xbar_scheduler_pkg.sv | 17 +
 rtl/spine_xbar_scheduler_if.sv | 24 ++
 rtl/spine_xbar_scheduler_rr_arbiter.sv | 46 ++++
 rtl/spine_xbar_scheduler.sv | 67 ++++++
 tb/tb_spine_xbar_scheduler.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/spine_xbar_scheduler_pkg.sv
// Shared constants and types for the spine router crossbar scheduler.
// Ports 0..3 face the leaf switches and ports 4..10 face the group links.
package spine_pkg;
    localparam int NUM_PORTS   = 11;
    localparam int PIDX_W      = 4;
    localparam int LEAF_FIRST  = 0;
    localparam int LEAF_LAST   = 3;
    localparam int GROUP_FIRST = 4;
    localparam int GROUP_LAST  = 10;

    typedef logic [PIDX_W-1:0] pidx_t;

    // Advance a port index by one, wrapping from the last port back to 0.
    function automatic pidx_t wrap_inc(input pidx_t p);
        return (p == pidx_t'(NUM_PORTS - 1)) ? '0 : pidx_t'(p + 1'b1);
    endfunction
endpackage

// File: rtl/spine_xbar_scheduler_if.sv
// Request/grant bundle between the router port FIFOs and the scheduler.
interface spine_xbar_if;
    import spine_pkg::*;

    logic                          enable;
    logic [NUM_PORTS-1:0]          req_valid;
    logic [NUM_PORTS*PIDX_W-1:0]   req_port;
    logic [NUM_PORTS-1:0]          out_full;
    logic [NUM_PORTS-1:0]          in_pop;
    logic [NUM_PORTS*PIDX_W-1:0]   xbar_sel;
    logic [NUM_PORTS-1:0]          xbar_valid;
    logic                          err_bad_dest;
    logic                          busy;

    modport master (
        output enable, req_valid, req_port, out_full,
        input  in_pop, xbar_sel, xbar_valid, err_bad_dest, busy
    );

    modport slave (
        input  enable, req_valid, req_port, out_full,
        output in_pop, xbar_sel, xbar_valid, err_bad_dest, busy
    );
endinterface

// File: rtl/spine_xbar_scheduler_rr_arbiter.sv
// Round-robin arbiter for one output port: combinational grant, registered
// pointer that moves to one past the winner.
module rr_arbiter
    import spine_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 eligible,
    input  logic [NUM_PORTS-1:0] req,
    output pidx_t                gnt_idx,
    output logic                 gnt_valid
);
    pidx_t rr_ptr_q;
    pidx_t rr_ptr_d;
    int    idx;

    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        idx       = 0;
        if (eligible) begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                idx = int'(rr_ptr_q) + k;
                if (idx >= NUM_PORTS) begin
                    idx = idx - NUM_PORTS;
                end
                if (!gnt_valid && req[idx]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = pidx_t'(idx);
                end
            end
        end
    end

    always_comb begin
        rr_ptr_d = gnt_valid ? wrap_inc(gnt_idx) : rr_ptr_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
endmodule

// File: rtl/spine_xbar_scheduler.sv
// Per-cycle crossbar scheduler: decodes head-flit destinations, runs one
// round-robin arbiter per output and merges grants and drops into in_pop.
module spine_xbar_scheduler
    import spine_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    spine_xbar_if.slave  bus
);
    pidx_t                dest      [NUM_PORTS];
    pidx_t                gnt_idx   [NUM_PORTS];
    logic [NUM_PORTS-1:0] gnt_valid;
    logic [NUM_PORTS-1:0] bad_dest;
    logic [NUM_PORTS-1:0] drop;
    logic [NUM_PORTS-1:0] pop;
    logic                 active;

    // Nothing may pop while in reset, so a mid-stream reset loses no flits.
    assign active = bus.enable & ~reset;

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_in
            assign dest[gi]     = bus.req_port[gi*PIDX_W +: PIDX_W];
            assign bad_dest[gi] = bus.req_valid[gi] &&
                                  ((dest[gi] >= pidx_t'(NUM_PORTS)) || (dest[gi] == pidx_t'(gi)));
        end

        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_out
            logic [NUM_PORTS-1:0] col_req;

            always_comb begin
                col_req = '0;
                for (int i = 0; i < NUM_PORTS; i++) begin
                    col_req[i] = bus.req_valid[i] && (dest[i] == pidx_t'(gi)) && (i != gi);
                end
            end

            rr_arbiter u_arb (
                .clk       (clk),
                .reset     (reset),
                .eligible  (active & ~bus.out_full[gi]),
                .req       (col_req),
                .gnt_idx   (gnt_idx[gi]),
                .gnt_valid (gnt_valid[gi])
            );

            assign bus.xbar_sel[gi*PIDX_W +: PIDX_W] = gnt_idx[gi];
        end
    endgenerate

    assign drop = bad_dest & {NUM_PORTS{active}};

    // Each input names a single output, so at most one grant lands per input.
    always_comb begin
        pop = drop;
        for (int o = 0; o < NUM_PORTS; o++) begin
            if (gnt_valid[o]) begin
                pop[gnt_idx[o]] = 1'b1;
            end
        end
    end

    assign bus.in_pop       = pop;
    assign bus.xbar_valid   = gnt_valid;
    assign bus.err_bad_dest = |drop;
    assign bus.busy         = ~reset & (|bus.req_valid);
endmodule

// File: tb/tb_spine_xbar_scheduler.sv
// Directed bench for spine_xbar_scheduler: each task drives one scenario and
// checks against hand-computed expectations, sampling on the falling edge.
module tb_spine_xbar_scheduler;
    import spine_pkg::*;

    localparam int N = NUM_PORTS;

    logic clk = 1'b0;
    logic reset;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    spine_xbar_if bus ();

    spine_xbar_scheduler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic drive_idle();
        bus.enable    = 1'b1;
        bus.req_valid = '0;
        bus.req_port  = '0;
        bus.out_full  = '0;
    endtask

    task automatic set_dest(input int i, input int d);
        bus.req_port[i*PIDX_W +: PIDX_W] = pidx_t'(d);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [N-1:0] exp_pop;
        reset         = 1'b1;
        bus.req_valid = '1;
        for (int i = 0; i < N; i++) set_dest(i, (i + 1) % N);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total_cnt++;
            if (bus.in_pop !== '0) $display("FAIL reset_pop c=%0d got %h want 0", c, bus.in_pop);
            else pass_cnt++;
            total_cnt++;
            if (bus.xbar_valid !== '0) $display("FAIL reset_xvalid c=%0d got %h want 0", c, bus.xbar_valid);
            else pass_cnt++;
            total_cnt++;
            if (bus.xbar_sel !== '0) $display("FAIL reset_sel c=%0d got %h want 0", c, bus.xbar_sel);
            else pass_cnt++;
            total_cnt++;
            if (bus.err_bad_dest !== 1'b0 || bus.busy !== 1'b0)
                $display("FAIL reset_err_busy c=%0d got err=%b busy=%b want 0 0", c, bus.err_bad_dest, bus.busy);
            else pass_cnt++;
            next_cycle();
        end
        reset = 1'b0;
        drive_idle();
        bus.req_valid = (N'(1) << 2) | (N'(1) << 8);
        set_dest(2, 5);
        set_dest(8, 5);
        exp_pop = N'(1) << 2;
        @(negedge clk);
        total_cnt++;
        if (bus.xbar_sel[5*PIDX_W +: PIDX_W] !== pidx_t'(2) || bus.in_pop !== exp_pop || bus.busy !== 1'b1)
            $display("FAIL reset_first_grant got sel5=%0d pop=%h busy=%b want 2 %h 1",
                     bus.xbar_sel[5*PIDX_W +: PIDX_W], bus.in_pop, bus.busy, exp_pop);
        else pass_cnt++;
        $display("test_reset: first grant after release sel5=%0d", bus.xbar_sel[5*PIDX_W +: PIDX_W]);
        next_cycle();
        drive_idle();
    endtask

    task automatic test_single_flow();
        logic [N-1:0]        exp_pop;
        logic [N-1:0]        exp_xv;
        logic [N*PIDX_W-1:0] exp_sel;
        exp_pop = N'(1) << 2;
        exp_xv  = N'(1) << 7;
        exp_sel = '0;
        exp_sel[7*PIDX_W +: PIDX_W] = pidx_t'(2);
        bus.req_valid = exp_pop;
        set_dest(2, 7);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total_cnt++;
            if (bus.in_pop !== exp_pop || bus.xbar_valid !== exp_xv || bus.xbar_sel !== exp_sel)
                $display("FAIL single_flow c=%0d got pop=%h xv=%h sel=%h want %h %h %h",
                         c, bus.in_pop, bus.xbar_valid, bus.xbar_sel, exp_pop, exp_xv, exp_sel);
            else pass_cnt++;
            $display("test_single_flow c=%0d pop=%h xv=%h", c, bus.in_pop, bus.xbar_valid);
            next_cycle();
        end
        drive_idle();
    endtask

    task automatic test_round_robin();
        int           order [6] = '{0, 3, 5, 0, 3, 5};
        logic [N-1:0] exp_pop;
        bus.req_valid = (N'(1) << 0) | (N'(1) << 3) | (N'(1) << 5);
        set_dest(0, 9);
        set_dest(3, 9);
        set_dest(5, 9);
        for (int k = 0; k < 6; k++) begin
            exp_pop = '0;
            exp_pop[order[k]] = 1'b1;
            @(negedge clk);
            total_cnt++;
            if (bus.xbar_sel[9*PIDX_W +: PIDX_W] !== pidx_t'(order[k]) || bus.in_pop !== exp_pop
                || bus.xbar_valid !== (N'(1) << 9))
                $display("FAIL round_robin k=%0d got sel9=%0d pop=%h xv=%h want %0d %h %h", k,
                         bus.xbar_sel[9*PIDX_W +: PIDX_W], bus.in_pop, bus.xbar_valid,
                         order[k], exp_pop, N'(1) << 9);
            else pass_cnt++;
            $display("test_round_robin k=%0d winner=%0d", k, bus.xbar_sel[9*PIDX_W +: PIDX_W]);
            next_cycle();
        end
        drive_idle();
    endtask

    task automatic test_backpressure();
        bus.req_valid = N'(1) << 1;
        set_dest(1, 4);
        bus.out_full  = N'(1) << 4;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total_cnt++;
            if (bus.in_pop !== '0 || bus.xbar_valid !== '0)
                $display("FAIL backpressure_hold c=%0d got pop=%h xv=%h want 0 0", c, bus.in_pop, bus.xbar_valid);
            else pass_cnt++;
            next_cycle();
        end
        bus.out_full = '0;
        @(negedge clk);
        total_cnt++;
        if (bus.in_pop !== (N'(1) << 1) || bus.xbar_sel[4*PIDX_W +: PIDX_W] !== pidx_t'(1))
            $display("FAIL backpressure_release got pop=%h sel4=%0d want %h 1",
                     bus.in_pop, bus.xbar_sel[4*PIDX_W +: PIDX_W], N'(1) << 1);
        else pass_cnt++;
        next_cycle();
        // Pointer of output 4 is now 2, so input 3 beats input 0.
        bus.req_valid = (N'(1) << 0) | (N'(1) << 3);
        set_dest(0, 4);
        set_dest(3, 4);
        @(negedge clk);
        total_cnt++;
        if (bus.xbar_sel[4*PIDX_W +: PIDX_W] !== pidx_t'(3) || bus.in_pop !== (N'(1) << 3))
            $display("FAIL backpressure_ptr got sel4=%0d pop=%h want 3 %h",
                     bus.xbar_sel[4*PIDX_W +: PIDX_W], bus.in_pop, N'(1) << 3);
        else pass_cnt++;
        $display("test_backpressure: post-release winner=%0d", bus.xbar_sel[4*PIDX_W +: PIDX_W]);
        next_cycle();
        drive_idle();
    endtask

    task automatic test_bad_dest();
        int dests [2] = '{6, 13};
        bus.req_valid = N'(1) << 6;
        for (int k = 0; k < 2; k++) begin
            set_dest(6, dests[k]);
            bus.out_full = (k == 1) ? '1 : '0;
            @(negedge clk);
            total_cnt++;
            if (bus.in_pop !== (N'(1) << 6) || bus.err_bad_dest !== 1'b1 || bus.xbar_valid !== '0)
                $display("FAIL bad_dest d=%0d got pop=%h err=%b xv=%h want %h 1 0",
                         dests[k], bus.in_pop, bus.err_bad_dest, bus.xbar_valid, N'(1) << 6);
            else pass_cnt++;
            $display("test_bad_dest d=%0d pop=%h err=%b", dests[k], bus.in_pop, bus.err_bad_dest);
            next_cycle();
        end
        bus.enable = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (bus.in_pop !== '0 || bus.err_bad_dest !== 1'b0)
            $display("FAIL bad_dest_disabled got pop=%h err=%b want 0 0", bus.in_pop, bus.err_bad_dest);
        else pass_cnt++;
        next_cycle();
        drive_idle();
    endtask

    task automatic test_parallel_enable();
        logic [N*PIDX_W-1:0] exp_sel;
        exp_sel = '0;
        for (int o = 0; o < N; o++) exp_sel[o*PIDX_W +: PIDX_W] = pidx_t'((o + N - 1) % N);
        bus.req_valid = '1;
        for (int i = 0; i < N; i++) set_dest(i, (i + 1) % N);
        bus.enable = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total_cnt++;
            if (bus.in_pop !== '0 || bus.xbar_valid !== '0 || bus.err_bad_dest !== 1'b0 || bus.busy !== 1'b1)
                $display("FAIL enable_low c=%0d got pop=%h xv=%h err=%b busy=%b want 0 0 0 1",
                         c, bus.in_pop, bus.xbar_valid, bus.err_bad_dest, bus.busy);
            else pass_cnt++;
            next_cycle();
        end
        // Output 1 pointer must still be 0, so input 0 beats input 10.
        bus.enable    = 1'b1;
        bus.req_valid = (N'(1) << 0) | (N'(1) << 10);
        set_dest(10, 1);
        @(negedge clk);
        total_cnt++;
        if (bus.xbar_sel[1*PIDX_W +: PIDX_W] !== pidx_t'(0) || bus.in_pop !== (N'(1) << 0))
            $display("FAIL enable_ptr_hold got sel1=%0d pop=%h want 0 %h",
                     bus.xbar_sel[1*PIDX_W +: PIDX_W], bus.in_pop, N'(1) << 0);
        else pass_cnt++;
        next_cycle();
        bus.req_valid = '1;
        set_dest(10, 0);
        @(negedge clk);
        total_cnt++;
        if (bus.in_pop !== '1 || bus.xbar_valid !== '1 || bus.xbar_sel !== exp_sel)
            $display("FAIL parallel got pop=%h xv=%h sel=%h want %h %h %h",
                     bus.in_pop, bus.xbar_valid, bus.xbar_sel, {N{1'b1}}, {N{1'b1}}, exp_sel);
        else pass_cnt++;
        $display("test_parallel: pop=%h xv=%h", bus.in_pop, bus.xbar_valid);
        next_cycle();
        drive_idle();
    endtask

    initial begin
        drive_idle();
        reset = 1'b1;
        test_reset();
        test_single_flow();
        test_round_robin();
        test_backpressure();
        test_bad_dest();
        test_parallel_enable();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
